// File: rtl/lab8_soc_sysid_pkg.sv
// rtl/lab8_soc_sysid_pkg.sv - shared types and constants for the lab8 system-ID checker
//
// Purpose: check-sequence state encoding, sysid slave word addresses and the
// default expected ID/timestamp pair of the current .sof build.

package lab8_soc_sysid_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ID_REQ  = 3'd1,
        ID_DATA = 3'd2,
        TS_REQ  = 3'd3,
        TS_DATA = 3'd4,
        DONE    = 3'd5
    } state_t;

    localparam logic SYSID_ADDR_ID = 1'b0;
    localparam logic SYSID_ADDR_TS = 1'b1;

    localparam logic [31:0] DEFAULT_EXPECTED_ID        = 32'd0;
    localparam logic [31:0] DEFAULT_EXPECTED_TIMESTAMP = 32'd1511670715;

    // True while a read phase (request or data wait) is in progress.
    function automatic logic state_is_busy(state_t s);
        return (s != IDLE) && (s != DONE);
    endfunction

    // True for the phases that target the timestamp word.
    function automatic logic state_is_ts(state_t s);
        return (s == TS_REQ) || (s == TS_DATA);
    endfunction

endpackage

// File: rtl/lab8_soc_sysid_checker_if.sv
// rtl/lab8_soc_sysid_checker_if.sv - Avalon-MM read bus between the checker and the sysid slave
//
// Signals:
//   avm_address        word address (0 = ID, 1 = timestamp)
//   avm_read           read request
//   avm_readdata       read data
//   avm_waitrequest    slave stall
//   avm_readdatavalid  read data valid
// Modports: master (checker side), slave (sysid side).

interface lab8_soc_sysid_checker_if;
    logic        avm_address;
    logic        avm_read;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;
    logic        avm_readdatavalid;

    modport master (
        output avm_address,
        output avm_read,
        input  avm_readdata,
        input  avm_waitrequest,
        input  avm_readdatavalid
    );

    modport slave (
        input  avm_address,
        input  avm_read,
        output avm_readdata,
        output avm_waitrequest,
        output avm_readdatavalid
    );
endinterface

// File: rtl/lab8_soc_sysid_read_phase.sv
// rtl/lab8_soc_sysid_read_phase.sv - one Avalon read: accept, data capture strobe and phase timeout
//
// Ports:
//   clock, reset_n     clock, asynchronous active-low reset
//   i_req              owner is in a request state (avm_read is high)
//   i_data             owner is waiting for readdatavalid after an accept
//   i_waitrequest      slave stall
//   i_readdatavalid    slave data valid
//   o_accept           request taken by the slave this cycle
//   o_capture          avm_readdata holds the word for this phase this cycle
//   o_expire           phase ran out of cycles without a capture
//
// The same instance serves the ID and timestamp phases; its counter restarts
// whenever no phase is active or a phase ends, so it is always 0 on entry to
// a request state.

module lab8_soc_sysid_read_phase #(
    parameter bit          USE_READDATAVALID = 1'b1,
    parameter int unsigned TIMEOUT_CYCLES    = 255
) (
    input  logic clock,
    input  logic reset_n,
    input  logic i_req,
    input  logic i_data,
    input  logic i_waitrequest,
    input  logic i_readdatavalid,
    output logic o_accept,
    output logic o_capture,
    output logic o_expire
);

    // The phase may use cycles 0 .. TIMEOUT_CYCLES-1; it expires in the last
    // of those if nothing was captured.
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] r_cnt;
    logic        w_active;

    assign w_active = i_req | i_data;
    assign o_accept = i_req & ~i_waitrequest;

    // With readdatavalid the word may still land in the accept cycle itself;
    // a valid pulse outside the accept cycle or the data wait is ignored.
    generate
        if (USE_READDATAVALID) begin : g_rdv
            assign o_capture = (o_accept | i_data) & i_readdatavalid;
        end else begin : g_zero_latency
            assign o_capture = o_accept;
        end
    endgenerate

    assign o_expire = w_active & ~o_capture & (r_cnt >= TIMEOUT_LAST);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= 16'd0;
        end else if (!w_active || o_capture || o_expire) begin
            r_cnt <= 16'd0;
        end else begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

endmodule

// File: rtl/lab8_soc_sysid_checker.sv
// rtl/lab8_soc_sysid_checker.sv - reads sysid ID and timestamp words and reports pass/fail/timeout
//
// Ports:
//   clock              system clock
//   reset_n            asynchronous active-low reset
//   start              single-cycle pulse, honoured only in IDLE or DONE
//   avm                Avalon-MM read master (lab8_soc_sysid_checker_if.master)
//   busy               check sequence in progress
//   done               sequence finished, sticky until the next accepted start
//   pass               both words matched and no timeout (valid with done)
//   id_mismatch        captured ID word differs from EXPECTED_ID
//   ts_mismatch        captured timestamp differs from EXPECTED_TIMESTAMP
//   timeout            a read phase ran out of cycles
//   id_value           captured ID word (0 if never captured)
//   ts_value           captured timestamp word (0 if never captured)

module lab8_soc_sysid_checker
    import lab8_soc_sysid_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID        = DEFAULT_EXPECTED_ID,
    parameter logic [31:0] EXPECTED_TIMESTAMP = DEFAULT_EXPECTED_TIMESTAMP,
    parameter bit          USE_READDATAVALID  = 1'b1,
    parameter int unsigned TIMEOUT_CYCLES     = 255
) (
    input  logic                            clock,
    input  logic                            reset_n,
    input  logic                            start,
    lab8_soc_sysid_checker_if.master        avm,
    output logic                            busy,
    output logic                            done,
    output logic                            pass,
    output logic                            id_mismatch,
    output logic                            ts_mismatch,
    output logic                            timeout,
    output logic [31:0]                     id_value,
    output logic [31:0]                     ts_value
);

    state_t      r_state;
    logic        r_done;
    logic        r_pass;
    logic        r_id_mismatch;
    logic        r_ts_mismatch;
    logic        r_timeout;
    logic [31:0] r_id_value;
    logic [31:0] r_ts_value;

    logic        w_req;
    logic        w_data;
    logic        w_ts_phase;
    logic        w_accept;
    logic        w_capture;
    logic        w_expire;
    logic        w_start_ok;
    logic        w_id_ne;
    logic        w_ts_ne;

    assign w_req      = (r_state == ID_REQ) || (r_state == TS_REQ);
    assign w_data     = (r_state == ID_DATA) || (r_state == TS_DATA);
    assign w_ts_phase = state_is_ts(r_state);
    assign w_start_ok = start && !state_is_busy(r_state);

    assign w_id_ne = (avm.avm_readdata != EXPECTED_ID);
    assign w_ts_ne = (avm.avm_readdata != EXPECTED_TIMESTAMP);

    // Request outputs decode straight from the state register, so they hold
    // steady under waitrequest and drop as soon as reset is asserted.
    assign avm.avm_read    = w_req;
    assign avm.avm_address = (r_state == TS_REQ) ? SYSID_ADDR_TS : SYSID_ADDR_ID;

    lab8_soc_sysid_read_phase #(
        .USE_READDATAVALID (USE_READDATAVALID),
        .TIMEOUT_CYCLES    (TIMEOUT_CYCLES)
    ) u_read_phase (
        .clock           (clock),
        .reset_n         (reset_n),
        .i_req           (w_req),
        .i_data          (w_data),
        .i_waitrequest   (avm.avm_waitrequest),
        .i_readdatavalid (avm.avm_readdatavalid),
        .o_accept        (w_accept),
        .o_capture       (w_capture),
        .o_expire        (w_expire)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= IDLE;
            r_done        <= 1'b0;
            r_pass        <= 1'b0;
            r_id_mismatch <= 1'b0;
            r_ts_mismatch <= 1'b0;
            r_timeout     <= 1'b0;
            r_id_value    <= 32'd0;
            r_ts_value    <= 32'd0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (w_start_ok) begin
                        r_state       <= ID_REQ;
                        r_done        <= 1'b0;
                        r_pass        <= 1'b0;
                        r_id_mismatch <= 1'b0;
                        r_ts_mismatch <= 1'b0;
                        r_timeout     <= 1'b0;
                        r_id_value    <= 32'd0;
                        r_ts_value    <= 32'd0;
                    end
                end
                default: begin
                    // A capture in the final allowed cycle beats the timeout.
                    if (w_capture) begin
                        if (!w_ts_phase) begin
                            r_id_value    <= avm.avm_readdata;
                            r_id_mismatch <= w_id_ne;
                            r_state       <= TS_REQ;
                        end else begin
                            r_ts_value    <= avm.avm_readdata;
                            r_ts_mismatch <= w_ts_ne;
                            r_state       <= DONE;
                            r_done        <= 1'b1;
                            // ID compare is already registered; TS compare is
                            // taken live so pass lands together with done.
                            r_pass        <= !r_id_mismatch && !w_ts_ne;
                        end
                    end else if (w_expire) begin
                        r_timeout <= 1'b1;
                        r_done    <= 1'b1;
                        r_pass    <= 1'b0;
                        r_state   <= DONE;
                    end else if (w_req && w_accept) begin
                        // Only reachable with readdatavalid in use: accepted
                        // but the word has not arrived yet.
                        r_state <= w_ts_phase ? TS_DATA : ID_DATA;
                    end
                end
            endcase
        end
    end

    assign busy        = state_is_busy(r_state);
    assign done        = r_done;
    assign pass        = r_pass;
    assign id_mismatch = r_id_mismatch;
    assign ts_mismatch = r_ts_mismatch;
    assign timeout     = r_timeout;
    assign id_value    = r_id_value;
    assign ts_value    = r_ts_value;

endmodule

// File: tb/tb_lab8_soc_sysid_checker.sv
// tb/tb_lab8_soc_sysid_checker.sv - directed table-driven bench for lab8_soc_sysid_checker

module tb_lab8_soc_sysid_checker;

    localparam logic [31:0] TS_OK  = 32'd1511670715;
    localparam logic [31:0] B_ID   = 32'hCAFE_0001;
    localparam logic [31:0] B_TS   = 32'h1234_ABCD;

    logic clock = 1'b0;
    logic reset_n;
    logic start_a;
    logic start_b;

    always #5 clock = ~clock;

    lab8_soc_sysid_checker_if a_if();
    lab8_soc_sysid_checker_if b_if();

    logic        a_busy, a_done, a_pass, a_idm, a_tsm, a_to;
    logic [31:0] a_idv, a_tsv;
    logic        b_busy, b_done, b_pass, b_idm, b_tsm, b_to;
    logic [31:0] b_idv, b_tsv;

    // Zero-latency slave, short timeout.
    lab8_soc_sysid_checker #(
        .EXPECTED_ID        (32'd0),
        .EXPECTED_TIMESTAMP (TS_OK),
        .USE_READDATAVALID  (1'b0),
        .TIMEOUT_CYCLES     (8)
    ) dut_a (
        .clock (clock), .reset_n (reset_n), .start (start_a), .avm (a_if.master),
        .busy (a_busy), .done (a_done), .pass (a_pass), .id_mismatch (a_idm),
        .ts_mismatch (a_tsm), .timeout (a_to), .id_value (a_idv), .ts_value (a_tsv)
    );

    // Pipelined slave using readdatavalid.
    lab8_soc_sysid_checker #(
        .EXPECTED_ID        (B_ID),
        .EXPECTED_TIMESTAMP (B_TS),
        .USE_READDATAVALID  (1'b1),
        .TIMEOUT_CYCLES     (255)
    ) dut_b (
        .clock (clock), .reset_n (reset_n), .start (start_b), .avm (b_if.master),
        .busy (b_busy), .done (b_done), .pass (b_pass), .id_mismatch (b_idm),
        .ts_mismatch (b_tsm), .timeout (b_to), .id_value (b_idv), .ts_value (b_tsv)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // ---------------- slave A: waitrequest for a programmed number of cycles
    int          a_wait_id = 0, a_wait_ts = 0, a_hold = 0, a_cur = 0;
    logic [31:0] a_id_word = 32'd0, a_ts_word = TS_OK;

    initial begin
        a_if.avm_waitrequest   = 1'b0;
        a_if.avm_readdata      = 32'd0;
        a_if.avm_readdatavalid = 1'b0;
        forever begin
            @(negedge clock);
            if (a_if.avm_read === 1'b1) begin
                a_cur = a_if.avm_address ? a_wait_ts : a_wait_id;
                if (a_hold < a_cur) begin
                    a_if.avm_waitrequest = 1'b1;
                    a_hold++;
                end else begin
                    a_if.avm_waitrequest = 1'b0;
                    a_if.avm_readdata    = a_if.avm_address ? a_ts_word : a_id_word;
                    a_hold = 0;
                end
            end else begin
                a_if.avm_waitrequest = 1'b0;
                a_hold = 0;
            end
        end
    end

    // ---------------- slave B: never stalls, data b_lat cycles after accept
    int          b_lat = 0, b_cnt = 0;
    bit          b_pend = 1'b0;
    logic [31:0] b_word = 32'd0;

    initial begin
        b_if.avm_waitrequest   = 1'b0;
        b_if.avm_readdata      = 32'd0;
        b_if.avm_readdatavalid = 1'b0;
        forever begin
            @(negedge clock);
            b_if.avm_readdatavalid = 1'b0;
            if (reset_n !== 1'b1) begin
                b_pend = 1'b0;
            end else begin
                if (b_pend) begin
                    if (b_cnt == 0) begin
                        b_if.avm_readdatavalid = 1'b1;
                        b_if.avm_readdata      = b_word;
                        b_pend = 1'b0;
                    end else begin
                        b_cnt--;
                    end
                end
                if (b_if.avm_read === 1'b1) begin
                    b_word = b_if.avm_address ? B_TS : B_ID;
                    if (b_lat == 0) begin
                        b_if.avm_readdatavalid = 1'b1;
                        b_if.avm_readdata      = b_word;
                    end else begin
                        b_pend = 1'b1;
                        b_cnt  = b_lat - 1;
                    end
                end
            end
        end
    end

    // Start a check on A and count cycles until done (-1 if it never comes).
    task automatic run_a(input int wid, input int wts, input logic [31:0] idw,
                         input logic [31:0] tsw, output int cyc,
                         output logic busy1, output logic done1);
        @(negedge clock);
        a_wait_id = wid; a_wait_ts = wts; a_id_word = idw; a_ts_word = tsw;
        start_a = 1'b1;
        @(posedge clock); #1;
        start_a = 1'b0;
        cyc = 1; busy1 = a_busy; done1 = a_done;
        while (a_done !== 1'b1 && cyc < 60) begin
            @(posedge clock); #1;
            cyc++;
        end
        if (a_done !== 1'b1) cyc = -1;
    endtask

    task automatic wait_done_b(inout int cyc);
        while (b_done !== 1'b1 && cyc < 60) begin
            @(posedge clock); #1;
            cyc++;
        end
        if (b_done !== 1'b1) cyc = -1;
    endtask

    typedef struct {
        int          wait_id;
        int          wait_ts;
        logic [31:0] id_word;
        logic [31:0] ts_word;
        int          exp_cyc;
        logic        exp_pass;
        logic        exp_idm;
        logic        exp_tsm;
        logic        exp_to;
        logic [31:0] exp_idv;
        logic [31:0] exp_tsv;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
        $fatal(1);
    end

    initial begin
        int   cyc;
        logic busy1, done1;

        //          wid wts id_word        ts_word        cyc pass idm tsm to  idv            tsv
        vecs[0] = '{0,  0,  32'd0,         TS_OK,         3,  1,   0,  0,  0,  32'd0,         TS_OK};
        vecs[1] = '{4,  0,  32'd0,         TS_OK,         7,  1,   0,  0,  0,  32'd0,         TS_OK};
        vecs[2] = '{0,  0,  32'd0,         32'h5A1A0000,  3,  0,   0,  1,  0,  32'd0,         32'h5A1A0000};
        vecs[3] = '{0,  0,  32'h12345678,  TS_OK,         3,  0,   1,  0,  0,  32'h12345678,  TS_OK};
        vecs[4] = '{0,  1000, 32'd0,       TS_OK,         10, 0,   0,  0,  1,  32'd0,         32'd0};
        vecs[5] = '{7,  0,  32'd0,         TS_OK,         10, 1,   0,  0,  0,  32'd0,         TS_OK};
        vecs[6] = '{8,  0,  32'd0,         TS_OK,         9,  0,   0,  0,  1,  32'd0,         32'd0};
        vecs[7] = '{1,  7,  32'd0,         TS_OK,         11, 1,   0,  0,  0,  32'd0,         TS_OK};

        reset_n = 1'b0; start_a = 1'b0; start_b = 1'b0;
        #2;
        check("reset a flags", {a_busy, a_done, a_pass, a_idm, a_tsm, a_to, a_if.avm_read, a_if.avm_address}, 32'd0);
        check("reset b flags", {b_busy, b_done, b_pass, b_idm, b_tsm, b_to, b_if.avm_read, b_if.avm_address}, 32'd0);
        check("reset a id_value", a_idv, 32'd0);
        check("reset a ts_value", a_tsv, 32'd0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_a(vecs[i].wait_id, vecs[i].wait_ts, vecs[i].id_word, vecs[i].ts_word, cyc, busy1, done1);
            check($sformatf("v%0d done cycle", i), cyc, vecs[i].exp_cyc);
            check($sformatf("v%0d busy at cycle 1", i), busy1, 1'b1);
            check($sformatf("v%0d done clear at cycle 1", i), done1, 1'b0);
            check($sformatf("v%0d pass", i), a_pass, vecs[i].exp_pass);
            check($sformatf("v%0d id_mismatch", i), a_idm, vecs[i].exp_idm);
            check($sformatf("v%0d ts_mismatch", i), a_tsm, vecs[i].exp_tsm);
            check($sformatf("v%0d timeout", i), a_to, vecs[i].exp_to);
            check($sformatf("v%0d id_value", i), a_idv, vecs[i].exp_idv);
            check($sformatf("v%0d ts_value", i), a_tsv, vecs[i].exp_tsv);
            check($sformatf("v%0d busy/read at done", i), {a_busy, a_if.avm_read}, 32'd0);
        end

        // Request held stable through 4 cycles of waitrequest on the ID word.
        @(negedge clock);
        a_wait_id = 4; a_wait_ts = 0; a_id_word = 32'd0; a_ts_word = TS_OK;
        start_a = 1'b1;
        @(posedge clock); #1;
        start_a = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clock); #1;
            check($sformatf("hold c%0d wr/read/addr", k),
                  {a_if.avm_waitrequest, a_if.avm_read, a_if.avm_address}, 32'b110);
        end
        cyc = 4;
        @(posedge clock); #1; cyc = 5;
        while (a_done !== 1'b1 && cyc < 60) begin
            @(posedge clock); #1; cyc++;
        end
        check("hold done cycle", cyc, 32'd7);
        check("hold pass", a_pass, 1'b1);

        // TS request stuck: timeout exactly 8 cycles after TS_REQ entry (cycle 2);
        // a start landing on the DONE-entry edge is dropped.
        @(negedge clock);
        a_wait_id = 0; a_wait_ts = 1000;
        start_a = 1'b1;
        @(posedge clock); #1;
        start_a = 1'b0;
        repeat (8) @(posedge clock);
        #1;
        check("to c9 timeout/read/addr", {a_to, a_if.avm_read, a_if.avm_address}, 32'b011);
        @(negedge clock);
        start_a = 1'b1;
        @(posedge clock); #1;
        start_a = 1'b0;
        check("to c10 timeout/done/read/pass", {a_to, a_done, a_if.avm_read, a_pass}, 32'b1100);
        @(posedge clock); #1;
        check("to c11 start at done entry ignored", {a_busy, a_done}, 32'b01);

        // B: data two cycles after accept; start while busy is ignored.
        @(negedge clock);
        b_lat = 2;
        start_b = 1'b1;
        @(posedge clock); #1;
        start_b = 1'b0;
        @(negedge clock);
        start_b = 1'b1;
        @(posedge clock); #1;
        start_b = 1'b0;
        cyc = 2;
        wait_done_b(cyc);
        check("b lat2 done cycle", cyc, 32'd7);
        check("b lat2 pass", b_pass, 1'b1);
        check("b lat2 id_value", b_idv, B_ID);
        check("b lat2 ts_value", b_tsv, B_TS);
        @(posedge clock); #1;
        check("b lat2 no restart", {b_busy, b_done}, 32'b01);

        // B: readdatavalid in the accept cycle skips the data states.
        @(negedge clock);
        b_lat = 0;
        start_b = 1'b1;
        @(posedge clock); #1;
        start_b = 1'b0;
        cyc = 1;
        wait_done_b(cyc);
        check("b lat0 done cycle", cyc, 32'd3);
        check("b lat0 pass", b_pass, 1'b1);

        // B: reset in TS_DATA clears everything asynchronously.
        @(negedge clock);
        b_lat = 5;
        start_b = 1'b1;
        @(posedge clock); #1;
        start_b = 1'b0;
        repeat (8) @(posedge clock);
        #1;
        check("b c9 in TS_DATA busy/read/addr", {b_busy, b_if.avm_read, b_if.avm_address}, 32'b100);
        check("b c9 id captured", b_idv, B_ID);
        #2;
        reset_n = 1'b0;
        #1;
        check("async rst b flags", {b_busy, b_done, b_pass, b_idm, b_tsm, b_to, b_if.avm_read, b_if.avm_address}, 32'd0);
        check("async rst b id_value", b_idv, 32'd0);
        check("async rst b ts_value", b_tsv, 32'd0);
        check("async rst a flags", {a_busy, a_done, a_to}, 32'd0);
        repeat (2) @(negedge clock);
        b_pend = 1'b0;
        reset_n = 1'b1;

        @(negedge clock);
        b_lat = 1;
        start_b = 1'b1;
        @(posedge clock); #1;
        start_b = 1'b0;
        cyc = 1;
        wait_done_b(cyc);
        check("b after reset done cycle", cyc, 32'd5);
        check("b after reset pass/flags", {b_pass, b_idm, b_tsm, b_to}, 32'b1000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
